idelayctrl_seq: RTL
===================

// Module: idelayctrl_seq
// PURPOSE
//  Parametrised reset sequencer for NUM_CTRL IDELAYCTRL primitives sharing one REFCLK.
//  Waits a power-up interval, pulses RST, waits for every RDY with a timeout, retries a
//  bounded number of times, then reports lock or failure. Sits beside the IDELAY/IODELAY
//  users; its ready output gates the downstream I/O calibration logic.
// PARAMETERS
//  CLK_PERIOD  5       clk period in ns (clk is also REFCLK)
//  NUM_CTRL    1       number of IDELAYCTRL instances (>=1)
//  INIT_NS     100000  wait after reset/restart before first RST pulse
//  RST_NS      60      RST high time per attempt (>=52 ns device minimum)
//  TIMEOUT_NS  100000  max wait for all RDY after RST falls
//  MAX_RETRY   3       extra attempts after first timeout before FAIL (0..15)
// PORTS
//  clk          in   1         REFCLK and logic clock
//  reset        in   1         asynchronous, active-high
//  restart      in   1         1-cycle pulse: rerun sequence from INIT
//  ready        out  1         all RDY high and state LOCKED
//  rdy_vec      out  NUM_CTRL  raw RDY of each instance, 2-flop synchronised
//  fail         out  1         retries exhausted; sticky until reset/restart
//  retry_cnt    out  4         attempts made beyond the first
//  idctl_rst    out  1         RST driven to all instances (for debug)
// BEHAVIOUR
//  Cycle counts: N_x = max(1, ceil(x_NS/CLK_PERIOD)); one shared down-counter,
//   width $clog2(max N)+1, loaded on each state entry, state advances when it reads 0.
//  Reset values: ready=0, fail=0, retry_cnt=0, idctl_rst=0, rdy_vec=0, state=INIT.
//  States:
//   INIT    idctl_rst=0; after N_INIT cycles -> PULSE
//   PULSE   idctl_rst=1 for exactly N_RST cycles -> WAIT
//   WAIT    idctl_rst=0; all rdy_vec=1 -> LOCKED; counter expiry:
//           retry_cnt<MAX_RETRY -> retry_cnt++, PULSE; else -> FAIL
//   LOCKED  ready=1 the cycle after entry (registered); no further RST pulses
//   FAIL    fail=1, idctl_rst=0, ready=0; exits only on reset/restart
//  restart in any state: next cycle state=INIT, ready=0, fail=0, retry_cnt=0, idctl_rst=0.
//  restart and reset together: reset wins. Async reset mid-PULSE drops idctl_rst at once.
//  RDY rising in the same cycle as WAIT expiry: lock wins (-> LOCKED, no retry).
//  ready = (state==LOCKED) & (&rdy_vec), registered; a RDY drop clears ready in 1 cycle.
//  retry_cnt saturates at MAX_RETRY; never wraps.
// CONFIGURATION
//  IDELAYCTRL_RELOCK_EN defined: in LOCKED, any rdy_vec bit low for 2 consecutive cycles
//   -> retry_cnt cleared, state PULSE (no INIT wait); normal retry/FAIL rules then apply.
//  Undefined: LOCKED is terminal; a RDY drop only clears ready (re-asserts if RDY returns).
// STRUCTURE
//  Package idelayctrl_pkg: state enum encoding (INIT,PULSE,WAIT,LOCKED,FAIL),
//   ns_to_cycles() constant function, RETRY_W=4.
//  One sub-module: idelayctrl_seq_fsm (states, counter, retry logic); top instantiates it
//   plus a generate loop of NUM_CTRL IDELAYCTRL primitives and the RDY synchronisers.
// TESTING (CLK_PERIOD=5, INIT_NS=500, RST_NS=60, TIMEOUT_NS=1000, NUM_CTRL=2, MAX_RETRY=2)
//  1 release reset -> idctl_rst high at cycle 100 for 12 cycles; both RDY up -> ready=1,
//    fail=0, retry_cnt=0.
//  2 force RDY[1]=0 for whole run -> 3 RST pulses 200 cycles apart; fail=1, retry_cnt=2,
//    ready=0.
//  3 force RDY[0]=0 during attempt 1 only -> second pulse, then LOCKED, retry_cnt=1.
//  4 restart while in FAIL -> fail=0, retry_cnt=0, idctl_rst after 100 cycles, lock.
//  5 assert reset during PULSE -> idctl_rst=0 same cycle; full sequence restarts.
//  6 in LOCKED force RDY[0]=0 3 cycles: RELOCK_EN -> ready=0, new RST pulse within 3
//    cycles; without it -> ready=0 then ready=1 after release, no pulse.

Source files
------------

// File: rtl/idelayctrl_pkg.sv
// Shared types and helpers for the IDELAYCTRL reset sequencer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package idelayctrl_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Round a duration up to whole clock periods, never below one cycle.
    function automatic int ns_to_cycles(input int ns, input int period);
        int c;
        c = (ns + period - 1) / period;
        if (c < 1) c = 1;
        return c;
    endfunction

endpackage

// File: rtl/IDELAYCTRL.sv
// Behavioural stand-in for the vendor IDELAYCTRL primitive; the implementation flow binds the library cell.
// Latency: RDY rises 8 REFCLK cycles after RST falls; RST clears RDY asynchronously.
// Backpressure: none.
//  REFCLK in 1 : reference clock
//  RST    in 1 : active-high asynchronous reset of the delay calibration
//  RDY    out 1: calibration locked
module IDELAYCTRL (
    input  logic REFCLK,
    input  logic RST,
    output logic RDY
);
    logic [2:0] r_cnt;

    always_ff @(posedge REFCLK or posedge RST) begin
        if (RST) begin
            r_cnt <= 3'd0;
            RDY   <= 1'b0;
        end else if (!RDY) begin
            if (r_cnt == 3'd7) RDY   <= 1'b1;
            else               r_cnt <= r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/idelayctrl_seq_fsm.sv
// Sequencer core: INIT wait, RST pulse, RDY wait with timeout, bounded retries, LOCKED/FAIL.
// Latency: all outputs registered; ready follows (LOCKED & all RDY) by one cycle.
// Backpressure: none; restart has priority over every state, async reset over restart.
//  clk, reset         : clock and asynchronous active-high reset
//  i_restart          : 1-cycle pulse, rerun from INIT
//  i_rdy_vec          : synchronised RDY of every instance
//  o_ready/o_fail     : lock status / retries exhausted (sticky)
//  o_retry_cnt        : attempts beyond the first, saturating at MAX_RETRY
//  o_idctl_rst        : RST to all IDELAYCTRL instances
// Optional: IDELAYCTRL_RELOCK_EN makes LOCKED re-pulse after a 2-cycle RDY loss.
module idelayctrl_seq_fsm
    import idelayctrl_pkg::*;
#(
    parameter int NUM_CTRL  = 1,
    parameter int N_INIT    = 20000,
    parameter int N_RST     = 12,
    parameter int N_TO      = 20000,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_restart,
    input  logic [NUM_CTRL-1:0] i_rdy_vec,
    output logic                o_ready,
    output logic                o_fail,
    output logic [RETRY_W-1:0]  o_retry_cnt,
    output logic                o_idctl_rst
);
    localparam int N_MAX = (N_INIT > N_RST) ? ((N_INIT > N_TO) ? N_INIT : N_TO)
                                            : ((N_RST  > N_TO) ? N_RST  : N_TO);
    localparam int CNT_W = $clog2(N_MAX) + 1;

    // Counter is loaded with N-1 so that a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0]   LD_INIT   = CNT_W'(N_INIT - 1);
    localparam logic [CNT_W-1:0]   LD_RST    = CNT_W'(N_RST - 1);
    localparam logic [CNT_W-1:0]   LD_TO     = CNT_W'(N_TO - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic               r_rst;
    logic               r_fail;
    logic               r_ready;
    logic               w_all_rdy;
`ifdef IDELAYCTRL_RELOCK_EN
    logic               r_low;      // a RDY bit was low in the previous LOCKED cycle
`endif

    assign w_all_rdy = &i_rdy_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= LD_INIT;
            r_retry <= '0;
            r_rst   <= 1'b0;
            r_fail  <= 1'b0;
            r_ready <= 1'b0;
`ifdef IDELAYCTRL_RELOCK_EN
            r_low   <= 1'b0;
`endif
        end else if (i_restart) begin
            r_state <= ST_INIT;
            r_cnt   <= LD_INIT;
            r_retry <= '0;
            r_rst   <= 1'b0;
            r_fail  <= 1'b0;
            r_ready <= 1'b0;
`ifdef IDELAYCTRL_RELOCK_EN
            r_low   <= 1'b0;
`endif
        end else begin
            r_ready <= (r_state == ST_LOCKED) && w_all_rdy;
`ifdef IDELAYCTRL_RELOCK_EN
            r_low   <= 1'b0;
`endif
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_PULSE;
                        r_cnt   <= LD_RST;
                        r_rst   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= LD_TO;
                        r_rst   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Lock is tested before expiry so a late RDY still wins.
                    if (w_all_rdy) begin
                        r_state <= ST_LOCKED;
                    end else if (r_cnt == '0) begin
                        if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= ST_PULSE;
                            r_cnt   <= LD_RST;
                            r_rst   <= 1'b1;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_LOCKED: begin
`ifdef IDELAYCTRL_RELOCK_EN
                    // Two consecutive low samples filter a single-cycle glitch.
                    if (!w_all_rdy) begin
                        if (r_low) begin
                            r_retry <= '0;
                            r_state <= ST_PULSE;
                            r_cnt   <= LD_RST;
                            r_rst   <= 1'b1;
                        end else begin
                            r_low <= 1'b1;
                        end
                    end
`endif
                end
                ST_FAIL: begin
                    r_fail <= 1'b1;
                    r_rst  <= 1'b0;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= LD_INIT;
                    r_rst   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry;
    assign o_idctl_rst = r_rst;

endmodule

// File: rtl/idelayctrl_seq.sv
// Reset sequencer for NUM_CTRL IDELAYCTRL instances sharing one REFCLK (clk).
// Latency: RDY reaches rdy_vec after 2 flops; ready one cycle after LOCKED with all RDY high.
// Backpressure: none; ready gates downstream I/O calibration.
//  clk       in  1        : REFCLK and logic clock
//  reset     in  1        : asynchronous, active-high
//  restart   in  1        : 1-cycle pulse, rerun sequence from INIT
//  ready     out 1        : all RDY high and LOCKED
//  rdy_vec   out NUM_CTRL : synchronised RDY per instance
//  fail      out 1        : retries exhausted, sticky until reset/restart
//  retry_cnt out 4        : attempts beyond the first
//  idctl_rst out 1        : RST driven to all instances
// Optional: IDELAYCTRL_RELOCK_EN re-runs the RST pulse after RDY loss while locked.
module idelayctrl_seq
    import idelayctrl_pkg::*;
#(
    parameter int CLK_PERIOD = 5,
    parameter int NUM_CTRL   = 1,
    parameter int INIT_NS    = 100000,
    parameter int RST_NS     = 60,
    parameter int TIMEOUT_NS = 100000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    output logic                ready,
    output logic [NUM_CTRL-1:0] rdy_vec,
    output logic                fail,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic                idctl_rst
);
    localparam int N_INIT = ns_to_cycles(INIT_NS, CLK_PERIOD);
    localparam int N_RST  = ns_to_cycles(RST_NS, CLK_PERIOD);
    localparam int N_TO   = ns_to_cycles(TIMEOUT_NS, CLK_PERIOD);

    logic [NUM_CTRL-1:0] w_rdy_prim;
    logic [NUM_CTRL-1:0] w_rdy_raw;
    logic [NUM_CTRL-1:0] r_rdy_s1;
    logic [NUM_CTRL-1:0] r_rdy_s2;
    logic                w_idctl_rst;

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        IDELAYCTRL u_idc (
            .REFCLK (clk),
            .RST    (w_idctl_rst),
            .RDY    (w_rdy_prim[g])
        );
    end

    assign w_rdy_raw = w_rdy_prim;

    // RDY is asynchronous to clk once RST is applied; two flops before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_s1 <= '0;
            r_rdy_s2 <= '0;
        end else begin
            r_rdy_s1 <= w_rdy_raw;
            r_rdy_s2 <= r_rdy_s1;
        end
    end

    idelayctrl_seq_fsm #(
        .NUM_CTRL  (NUM_CTRL),
        .N_INIT    (N_INIT),
        .N_RST     (N_RST),
        .N_TO      (N_TO),
        .MAX_RETRY (MAX_RETRY)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_restart   (restart),
        .i_rdy_vec   (r_rdy_s2),
        .o_ready     (ready),
        .o_fail      (fail),
        .o_retry_cnt (retry_cnt),
        .o_idctl_rst (w_idctl_rst)
    );

    assign rdy_vec   = r_rdy_s2;
    assign idctl_rst = w_idctl_rst;

endmodule
